wb_pipe_mem_responder: RTL and testbench
========================================

// Module: wb_pipe_mem_responder
// PURPOSE
//  Pipelined Wishbone B4 responder (slave) modelling instruction/data memory for processorci_top.
//  Terminates the core_* or data_mem_* initiator bus in simulation benches and FPGA loopback builds.
//  Accepts one request per cycle and returns ack after a fixed latency.
//  Throttles with stall when the in-flight limit is reached.
// PARAMETERS
//  MEM_WORDS    4096  depth in 32-bit words; power of two
//  LATENCY      2     cycles from request acceptance to ack; legal 1..8
//  MAX_OUTST    2     max in-flight (accepted, not yet acked) requests; legal 1..LATENCY
//  MEM_FILE     ""    $readmemh init file; empty = zero-filled
// PORTS
//  sys_clk      in   1   clock; all logic on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  wb_cyc_i     in   1   bus cycle active
//  wb_stb_i     in   1   request strobe
//  wb_we_i      in   1   1 = write, 0 = read
//  wb_sel_i     in   4   byte lane enables (write only)
//  wb_addr_i    in   32  byte address
//  wb_data_i    in   32  write data
//  wb_data_o    out  32  read data, valid with wb_ack_o
//  wb_ack_o     out  1   one-cycle response strobe per accepted request
//  wb_stall_o   out  1   request not accepted this cycle
//  wb_err_o     out  1   error response; present only with WB_RESP_ERR_EN
// BEHAVIOUR
//  Reset values: wb_ack_o=0, wb_err_o=0, wb_data_o=0, wb_stall_o=0, in-flight count=0, pipe empty.
//  Memory contents are not reset.
//  Accept = cyc & stb & ~stall. Memory action happens at the accepting edge.
//  Write: lanes with sel[n]=1 are written; lanes with sel[n]=0 keep their value. Response data = 0.
//  Read: the word is captured at the accepting edge. Read-after-write of the prior cycle returns the new data.
//  Word index = wb_addr_i[log2(MEM_WORDS)+1:2]. Bits [1:0] are ignored.
//  Each accepted request enters a LATENCY-stage shift pipe.
//  wb_ack_o and wb_data_o are driven from the last stage, exactly LATENCY cycles after acceptance.
//  In-order, no reordering; back-to-back accepts give back-to-back acks.
//  In-flight counter: +1 on accept, -1 on ack; simultaneous accept and ack leaves it unchanged.
//  Counter width: $clog2(MAX_OUTST+1).
//  wb_stall_o (combinational from registered state) = (count == MAX_OUTST) & ~ack_this_cycle.
//  The slot freed by an ack may be reused in the same cycle.
//  With MAX_OUTST < LATENCY, throughput is MAX_OUTST per LATENCY cycles.
//  cyc drop (wb_cyc_i=0) flushes all pipe stages and clears the counter on the next edge.
//  No ack is emitted for flushed requests. Writes already accepted remain committed.
//  stb while ~cyc is ignored.
//  Asynchronous reset mid-transfer clears the pipe, count, ack and err immediately.
// CONFIGURATION
//  WB_RESP_ERR_EN defined:
//    A byte address >= MEM_WORDS*4 answers with wb_err_o instead of wb_ack_o, same latency and ordering.
//    No memory write occurs; wb_data_o = 0. Counter decrements on err exactly as on ack.
//  WB_RESP_ERR_EN undefined:
//    No wb_err_o port. Out-of-range addresses alias by index truncation and always ack.
// STRUCTURE
//  Package processorci_wb_pkg:
//    typedef wb_resp_t {logic [31:0] data; logic err;}
//    localparams WB_DATA_W=32, WB_SEL_W=4
//  Sub-module wb_resp_pipe #(DEPTH):
//    valid+payload shift register of wb_resp_t with synchronous flush and async reset
//  Top level holds: byte-lane RAM, accept logic, in-flight counter.
// TESTING
//  1 Reset (LATENCY=2): write 0xDEADBEEF @0x10 sel=F, then read @0x10 -> ack 2 cycles after each accept, read data 0xDEADBEEF.
//  2 Byte lanes: preload 0x11223344 @0x20; write 0xAABBCCDD sel=0101 -> read returns 0x11BB33DD.
//  3 Back-pressure (LATENCY=3, MAX_OUTST=2): stb held 4 cycles -> stall high in cycle 2, accepts on cycles 0,1,3.
//    Acks on cycles 3,4,6; ack count = accepts.
//  4 Flush: accept 2 reads, drop cyc the next cycle -> no ack ever; a new read on re-assert acks after exactly LATENCY.
//  5 Reset mid-op: assert rst_n=0 with 2 in flight -> ack/stall 0 immediately; after release, the first request acks normally.
//  6 With WB_RESP_ERR_EN, MEM_WORDS=1024: write @0x1000 -> err (no ack) after LATENCY; read @0xFFC unchanged.
//    Without the macro, the same write aliases to @0x0 and acks.

Source files
------------

// File: rtl/wb_pipe_mem_responder_pkg.sv
// processorci_wb_pkg
//   Shared types and constants for the pipelined Wishbone memory responder.
//   wb_resp_t  : response payload carried through the latency pipe
//   lane_merge : byte-lane write merge used by the RAM write port
// Optional feature macro used by the design: WB_RESP_ERR_EN
package processorci_wb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = 4;

  typedef struct packed {
    logic [WB_DATA_W-1:0] data;
    logic                 err;
  } wb_resp_t;

  // Lanes with sel set take the new byte, the rest keep the old one.
  function automatic logic [WB_DATA_W-1:0] lane_merge(
    input logic [WB_DATA_W-1:0] old_w,
    input logic [WB_DATA_W-1:0] new_w,
    input logic [WB_SEL_W-1:0]  sel
  );
    logic [WB_DATA_W-1:0] res;
    res = old_w;
    for (int unsigned b = 0; b < WB_SEL_W; b++) begin
      if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_pipe_mem_responder_if.sv
// wb_pipe_mem_responder_if
//   Pipelined Wishbone B4 bus bundle between an initiator and the responder.
//   master modport : drives cyc/stb/we/sel/addr/data_i, receives data_o/ack/stall(/err)
//   slave  modport : the mirror image
//   wb_err_o exists only when WB_RESP_ERR_EN is defined.
interface wb_pipe_mem_responder_if
  import processorci_wb_pkg::*;
();
  logic                 wb_cyc_i;
  logic                 wb_stb_i;
  logic                 wb_we_i;
  logic [WB_SEL_W-1:0]  wb_sel_i;
  logic [31:0]          wb_addr_i;
  logic [WB_DATA_W-1:0] wb_data_i;
  logic [WB_DATA_W-1:0] wb_data_o;
  logic                 wb_ack_o;
  logic                 wb_stall_o;
`ifdef WB_RESP_ERR_EN
  logic                 wb_err_o;
`endif

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_addr_i, wb_data_i,
    input  wb_data_o, wb_ack_o, wb_stall_o
`ifdef WB_RESP_ERR_EN
    , input wb_err_o
`endif
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_addr_i, wb_data_i,
    output wb_data_o, wb_ack_o, wb_stall_o
`ifdef WB_RESP_ERR_EN
    , output wb_err_o
`endif
  );

endinterface

// File: rtl/wb_pipe_mem_responder_resp_pipe.sv
// wb_resp_pipe
//   DEPTH-stage valid + payload shift register of wb_resp_t.
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : synchronous clear of every stage
//   in_valid, in_resp : stage-0 load
//   out_valid, out_resp : last stage
module wb_resp_pipe
  import processorci_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  logic     in_valid,
  input  wb_resp_t in_resp,
  output logic     out_valid,
  output wb_resp_t out_resp
);

  logic [DEPTH-1:0] valid_q, valid_d;
  wb_resp_t         resp_q [DEPTH];
  wb_resp_t         resp_d [DEPTH];

  always_comb begin
    valid_d = valid_q;
    resp_d  = resp_q;
    if (flush) begin
      valid_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) resp_d[i] = '0;
    end else begin
      valid_d[0] = in_valid;
      resp_d[0]  = in_valid ? in_resp : '0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        resp_d[i]  = resp_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) resp_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      resp_q  <= resp_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_resp  = resp_q[DEPTH-1];

endmodule

// File: rtl/wb_pipe_mem_responder.sv
// wb_pipe_mem_responder
//   Pipelined Wishbone B4 responder modelling instruction/data memory.
//   One request accepted per cycle; ack (or err) returns LATENCY cycles later,
//   in order. Stall is raised when MAX_OUTST requests are in flight.
//   sys_clk : clock, rising edge
//   rst_n   : asynchronous active-low reset (memory contents are not reset)
//   wb      : slave modport of wb_pipe_mem_responder_if
// Parameters: MEM_WORDS (power of two), LATENCY (1..8), MAX_OUTST (1..LATENCY),
//   MEM_FILE (memory image name).
// Macro WB_RESP_ERR_EN: out-of-range byte addresses answer with wb_err_o and
//   do not write; otherwise addresses alias by index truncation.
module wb_pipe_mem_responder
  import processorci_wb_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned MAX_OUTST = 2,
  parameter string       MEM_FILE  = ""
) (
  input logic                    sys_clk,
  input logic                    rst_n,
  wb_pipe_mem_responder_if.slave wb
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(MAX_OUTST + 1);

  logic [WB_DATA_W-1:0] mem_q [MEM_WORDS];

  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          stall;
  logic          accept;
  logic          mem_we;
  logic          resp_vis;
  wb_resp_t      req_resp;
  logic          last_valid;
  wb_resp_t      last_resp;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    word_idx = wb.wb_addr_i[AW+1:2];
    in_range = 1'b1;
`ifdef WB_RESP_ERR_EN
    in_range = (wb.wb_addr_i[31:AW+2] == '0);
`endif
    // A response leaving the pipe this cycle frees its slot immediately.
    stall    = (count_q == CW'(MAX_OUTST)) && !last_valid;
    accept   = wb.wb_cyc_i && wb.wb_stb_i && !stall;
    mem_we   = accept && wb.wb_we_i && in_range;

    // Read data is taken from the array as it stands before this edge's write,
    // which already includes a write accepted on the previous edge.
    req_resp.err  = !in_range;
    req_resp.data = (wb.wb_we_i || !in_range) ? '0 : mem_q[word_idx];

    count_d = count_q;
    if (!wb.wb_cyc_i) begin
      count_d = '0;
    end else if (accept && !last_valid) begin
      count_d = count_q + 1'b1;
    end else if (!accept && last_valid) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (mem_we) mem_q[word_idx] <= lane_merge(mem_q[word_idx], wb.wb_data_i, wb.wb_sel_i);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  wb_resp_pipe #(
    .DEPTH (LATENCY)
  ) u_resp_pipe (
    .clk       (sys_clk),
    .rst_n     (rst_n),
    .flush     (!wb.wb_cyc_i),
    .in_valid  (accept),
    .in_resp   (req_resp),
    .out_valid (last_valid),
    .out_resp  (last_resp)
  );

  // The last stage is masked while cyc is low: those requests are being
  // flushed on this edge and must never be answered.
  assign resp_vis      = last_valid && wb.wb_cyc_i;
  assign wb.wb_ack_o   = resp_vis && !last_resp.err;
  assign wb.wb_data_o  = resp_vis ? last_resp.data : '0;
  assign wb.wb_stall_o = stall;
`ifdef WB_RESP_ERR_EN
  assign wb.wb_err_o   = resp_vis && last_resp.err;
`endif

  logic unused_addr_bits;
`ifdef WB_RESP_ERR_EN
  assign unused_addr_bits = ^wb.wb_addr_i[1:0];
`else
  assign unused_addr_bits = ^{wb.wb_addr_i[31:AW+2], wb.wb_addr_i[1:0]};
`endif

endmodule

// File: tb/tb_wb_pipe_mem_responder.sv
module tb_wb_pipe_mem_responder;
  import processorci_wb_pkg::*;

  logic sys_clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  wb_pipe_mem_responder_if bus_a ();
  wb_pipe_mem_responder_if bus_b ();

  wb_pipe_mem_responder #(
    .MEM_WORDS (1024),
    .LATENCY   (2),
    .MAX_OUTST (2)
  ) dut_a (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .wb      (bus_a.slave)
  );

  wb_pipe_mem_responder #(
    .MEM_WORDS (1024),
    .LATENCY   (3),
    .MAX_OUTST (2)
  ) dut_b (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .wb      (bus_b.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_a();
    bus_a.wb_cyc_i = 1'b0; bus_a.wb_stb_i = 1'b0; bus_a.wb_we_i = 1'b0;
    bus_a.wb_sel_i = '0; bus_a.wb_addr_i = '0; bus_a.wb_data_i = '0;
  endtask

  task automatic idle_b();
    bus_b.wb_cyc_i = 1'b0; bus_b.wb_stb_i = 1'b0; bus_b.wb_we_i = 1'b0;
    bus_b.wb_sel_i = '0; bus_b.wb_addr_i = '0; bus_b.wb_data_i = '0;
  endtask

  task automatic drive_a(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                         input logic [31:0] wdat);
    bus_a.wb_cyc_i = 1'b1; bus_a.wb_stb_i = 1'b1; bus_a.wb_we_i = we;
    bus_a.wb_sel_i = sel;  bus_a.wb_addr_i = addr; bus_a.wb_data_i = wdat;
  endtask

  // Single request on bus A, called just after a rising edge (cycle 0).
  // lat = index of the cycle in which the response is seen, -1 if none.
  task automatic req_a(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                       input logic [31:0] wdat, output int lat, output logic [31:0] rdat,
                       output logic ackd, output logic errd);
    lat = -1; rdat = '0; ackd = 1'b0; errd = 1'b0;
    drive_a(we, sel, addr, wdat);
    for (int c = 0; c < 16 && lat < 0; c++) begin
      @(negedge sys_clk);
      ackd = bus_a.wb_ack_o;
`ifdef WB_RESP_ERR_EN
      errd = bus_a.wb_err_o;
`endif
      if (ackd || errd) begin
        lat  = c;
        rdat = bus_a.wb_data_o;
      end
      @(posedge sys_clk); #1;
      bus_a.wb_stb_i = 1'b0;
    end
    bus_a.wb_cyc_i = 1'b0;
    @(posedge sys_clk); #1;
  endtask

  int          lat;
  logic [31:0] rdat;
  logic        ackd, errd;
  logic [9:0]  ack_mask;
  logic [3:0]  stall_mask;
  logic [31:0] dat [8];
  int          k;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle_a();
    idle_b();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_eq("rst_ack",   32'(bus_a.wb_ack_o),   32'd0);
    check_eq("rst_stall", 32'(bus_a.wb_stall_o), 32'd0);
    check_eq("rst_data",  bus_a.wb_data_o,       32'd0);
`ifdef WB_RESP_ERR_EN
    check_eq("rst_err",   32'(bus_a.wb_err_o),   32'd0);
`endif
    rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // Basic write then read
    req_a(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rdat, ackd, errd);
    check_eq("t1_wr_lat", 32'(lat), 32'd2);
    check_eq("t1_wr_data", rdat, 32'd0);
    req_a(1'b0, 4'h0, 32'h10, 32'h0, lat, rdat, ackd, errd);
    check_eq("t1_rd_lat", 32'(lat), 32'd2);
    check_eq("t1_rd_data", rdat, 32'hDEADBEEF);

    // Byte lanes; addr bits [1:0] ignored on the partial write
    req_a(1'b1, 4'hF, 32'h20, 32'h11223344, lat, rdat, ackd, errd);
    req_a(1'b1, 4'h5, 32'h23, 32'hAABBCCDD, lat, rdat, ackd, errd);
    check_eq("t2_wr_lat", 32'(lat), 32'd2);
    req_a(1'b0, 4'h0, 32'h20, 32'h0, lat, rdat, ackd, errd);
    check_eq("t2_rd_data", rdat, 32'h11BB33DD);

    // Back-to-back: write, read-after-write, read
    ack_mask = '0; stall_mask = '0;
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: drive_a(1'b1, 4'hF, 32'h40, 32'h0BADF00D);
        1: drive_a(1'b0, 4'h0, 32'h40, 32'h0);
        2: drive_a(1'b0, 4'h0, 32'h10, 32'h0);
        default: bus_a.wb_stb_i = 1'b0;
      endcase
      @(negedge sys_clk);
      if (c < 3 && bus_a.wb_stall_o) stall_mask[c] = 1'b1;
      if (bus_a.wb_ack_o) ack_mask[c] = 1'b1;
      dat[c] = bus_a.wb_data_o;
      @(posedge sys_clk); #1;
    end
    idle_a();
    check_eq("b2b_stall", 32'(stall_mask), 32'h0);
    check_eq("b2b_acks",  32'(ack_mask),   32'h1C);
    check_eq("b2b_d_wr",  dat[2], 32'h0);
    check_eq("b2b_d_raw", dat[3], 32'h0BADF00D);
    check_eq("b2b_d_rd",  dat[4], 32'hDEADBEEF);

    // Back-pressure on LATENCY=3, MAX_OUTST=2: stb held 4 cycles
    ack_mask = '0; stall_mask = '0; k = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin
        bus_b.wb_cyc_i = 1'b1; bus_b.wb_stb_i = 1'b1; bus_b.wb_we_i = 1'b1;
        bus_b.wb_sel_i = 4'hF; bus_b.wb_addr_i = 32'(k * 4); bus_b.wb_data_i = 32'(32'hA0 + k);
      end else begin
        bus_b.wb_stb_i = 1'b0;
      end
      @(negedge sys_clk);
      if (c < 4 && bus_b.wb_stall_o) stall_mask[c] = 1'b1;
      if (c < 4 && !bus_b.wb_stall_o) k++;
      if (bus_b.wb_ack_o) ack_mask[c] = 1'b1;
      @(posedge sys_clk); #1;
    end
    idle_b();
    check_eq("bp_stall",   32'(stall_mask), 32'h4);
    check_eq("bp_acks",    32'(ack_mask),   32'h58);
    check_eq("bp_accepts", 32'(k),          32'd3);
    check_eq("bp_ackcnt",  32'($countones(ack_mask)), 32'd3);

    // Flush: two reads, cyc dropped next cycle, no ack afterwards
    ack_mask = '0;
    drive_a(1'b0, 4'h0, 32'h10, 32'h0);
    @(posedge sys_clk); #1;
    drive_a(1'b0, 4'h0, 32'h20, 32'h0);
    @(posedge sys_clk); #1;
    idle_a();
    for (int c = 2; c < 8; c++) begin
      @(negedge sys_clk);
      if (bus_a.wb_ack_o) ack_mask[c] = 1'b1;
      @(posedge sys_clk); #1;
    end
    check_eq("fl_no_ack", 32'(ack_mask), 32'h0);
    req_a(1'b0, 4'h0, 32'h10, 32'h0, lat, rdat, ackd, errd);
    check_eq("fl_new_lat",  32'(lat), 32'd2);
    check_eq("fl_new_data", rdat,     32'hDEADBEEF);

    // Asynchronous reset with two requests in flight on both instances
    drive_a(1'b0, 4'h0, 32'h10, 32'h0);
    bus_b.wb_cyc_i = 1'b1; bus_b.wb_stb_i = 1'b1; bus_b.wb_we_i = 1'b0; bus_b.wb_addr_i = 32'h0;
    @(posedge sys_clk); #1;
    bus_a.wb_addr_i = 32'h14;
    bus_b.wb_addr_i = 32'h4;
    @(posedge sys_clk); #1;
    bus_a.wb_stb_i = 1'b0;
    bus_b.wb_stb_i = 1'b0;
    #1;
    check_eq("mr_pre_ack_a",   32'(bus_a.wb_ack_o),   32'd1);
    check_eq("mr_pre_stall_b", 32'(bus_b.wb_stall_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mr_ack_a",   32'(bus_a.wb_ack_o),   32'd0);
    check_eq("mr_data_a",  bus_a.wb_data_o,       32'd0);
    check_eq("mr_stall_b", 32'(bus_b.wb_stall_o), 32'd0);
    check_eq("mr_ack_b",   32'(bus_b.wb_ack_o),   32'd0);
    idle_a();
    idle_b();
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst_n = 1'b1;
    @(posedge sys_clk); #1;
    req_a(1'b0, 4'h0, 32'h10, 32'h0, lat, rdat, ackd, errd);
    check_eq("mr_post_lat",  32'(lat), 32'd2);
    check_eq("mr_post_data", rdat,     32'hDEADBEEF);

    // Out-of-range address with MEM_WORDS=1024
    req_a(1'b1, 4'hF, 32'h0,   32'h55AA55AA, lat, rdat, ackd, errd);
    req_a(1'b1, 4'hF, 32'hFFC, 32'h12345678, lat, rdat, ackd, errd);
    req_a(1'b1, 4'hF, 32'h1000, 32'hCAFEF00D, lat, rdat, ackd, errd);
    check_eq("oor_lat", 32'(lat), 32'd2);
`ifdef WB_RESP_ERR_EN
    check_eq("oor_err",  32'(errd), 32'd1);
    check_eq("oor_ack",  32'(ackd), 32'd0);
    check_eq("oor_data", rdat,      32'd0);
    req_a(1'b0, 4'h0, 32'h0, 32'h0, lat, rdat, ackd, errd);
    check_eq("oor_rd0", rdat, 32'h55AA55AA);
`else
    check_eq("oor_ack", 32'(ackd), 32'd1);
    req_a(1'b0, 4'h0, 32'h0, 32'h0, lat, rdat, ackd, errd);
    check_eq("oor_alias", rdat, 32'hCAFEF00D);
`endif
    req_a(1'b0, 4'h0, 32'hFFC, 32'h0, lat, rdat, ackd, errd);
    check_eq("oor_rdffc", rdat, 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
